decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Accepts one instruction per cycle through a valid/ready handshake and splits it into operand and selection fields.
- Resolves conditional jump, call and return using the zero flag, and keeps an internal return-address stack (RAS) of configurable depth.
- Sits between instruction fetch and the ALU/PC logic, with one pipeline register per output.

Parameters:
- PC_WIDTH, 5, width of program counter and jump/return addresses
- OPCODE_WIDTH, 6, opcode field width
- VALUE_WIDTH, 8, width of source1/source2/destination fields
- INSTRUCTION_WIDTH, 40, instruction word width; must be >= OPCODE_WIDTH+3*VALUE_WIDTH+8
- RAS_DEPTH, 4, return-address stack entries (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction and pc are valid
- in_ready  out  1  stage can accept an instruction
- instr  in  INSTRUCTION_WIDTH  instruction word
- pc  in  PC_WIDTH  address of instr
- zero_flag  in  1  ALU zero flag, sampled on acceptance
- flush  in  1  discard held output, no RAS change
- out_valid  out  1  registered outputs are valid
- out_ready  in  1  consumer accepts outputs
- op_code  out  OPCODE_WIDTH  instr[3V+8+OPCODE_WIDTH-1 : 3V+8], where V=VALUE_WIDTH
- source1  out  VALUE_WIDTH  instr[3V+7 : 2V+8]
- source2  out  VALUE_WIDTH  instr[2V+7 : V+8]
- destination  out  VALUE_WIDTH  instr[V+7 : 8]
- source1_choice / source2_choice / destination_choice  out  2 each  instr[5:4] / [3:2] / [1:0]; bits [7:6] are reserved and ignored
- jmp, cal, ret, push, pop  out  1 each  resolved control strobes
- target_addr  out  PC_WIDTH  jump/call target (source1[PC_WIDTH-1:0]), or the popped return address on ret
- ras_overflow, ras_underflow  out  1 each  sticky error flags

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, all field outputs and strobes =0, target_addr=0.
  - RAS pointer =0, RAS entries =0, both error flags =0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready: outputs load on that clk edge, so latency is 1 cycle.
  - Outputs are held stable while out_valid && !out_ready.
  - When out_valid && out_ready && no new accept, out_valid clears next cycle.
- Strobe resolution, on the accept cycle:
  - JMP, IF0JUMP (zero_flag=1), IF1JUMP (zero_flag=0): jmp=1.
  - CALL, CAL0 (zero=1), CAL1 (zero=0): push=1, jmp=1, cal=1. Push pc+1 (mod 2^PC_WIDTH) onto the RAS; target_addr=source1[PC_WIDTH-1:0].
  - RET, RET0 (zero=1), RET1 (zero=0): pop=1, ret=1. target_addr = top of RAS; the RAS pops.
  - Untaken conditional and all other opcodes: all strobes =0, target_addr=source1[PC_WIDTH-1:0].
- RAS boundaries:
  - Push when full: the oldest entry is discarded (circular), the push still takes effect, ras_overflow=1.
  - Pop when empty: target_addr=0, the pointer stays 0, ras_underflow=1.
  - Both error flags clear only on reset.
- Flush:
  - out_valid=0 next cycle.
  - If flush coincides with an accept, the instruction is dropped: no RAS push/pop and outputs are not loaded.
  - RAS effects of instructions already accepted are not undone.
- Reset mid-operation clears all state immediately, regardless of the handshake.
- Opcode constants (JMP, IF0JUMP, IF1JUMP, CALL, CAL0, CAL1, RET, RET0, RET1) come from the shared opcode definitions.

Test Plan:
1. Reset, then present MOV-type instr=40'h00_0A0B0C15 with pc=3 → one cycle later: out_valid=1, source1=0A, source2=0B, destination=0C, source1_choice=1, source2_choice=1, destination_choice=1, all strobes 0.
2. IF0JUMP with source1=8'h11 and zero_flag=1 → jmp=1, target_addr=5'h11. Same instruction with zero_flag=0 → jmp=0.
3. CALL at pc=7 with source1=8'h14, then RET → first output push/jmp/cal=1, target=14. Second output pop/ret=1, target_addr=8.
4. Five CALLs at pc=0..4 with RAS_DEPTH=4 → ras_overflow=1. Four RETs then return 5,4,3,2. A fifth RET gives target_addr=0 and ras_underflow=1.
5. Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release out_ready → next instruction appears on the following cycle with no loss or duplication.
6. Assert flush together with an accepted CALL → out_valid=0, RAS depth unchanged. Assert rst_n=0 mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage : registered instruction decoder with return-address stack
// Rev 1.0
// ----------------------------------------------------------------------------

package decode_opcodes_pkg;
  localparam logic [5:0] OP_JMP     = 6'h20;
  localparam logic [5:0] OP_IF0JUMP = 6'h21;
  localparam logic [5:0] OP_IF1JUMP = 6'h22;
  localparam logic [5:0] OP_CALL    = 6'h23;
  localparam logic [5:0] OP_CAL0    = 6'h24;
  localparam logic [5:0] OP_CAL1    = 6'h25;
  localparam logic [5:0] OP_RET     = 6'h26;
  localparam logic [5:0] OP_RET0    = 6'h27;
  localparam logic [5:0] OP_RET1    = 6'h28;
endpackage

module decode_stage #(
  parameter int PC_WIDTH          = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int VALUE_WIDTH       = 8,
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int RAS_DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic                         zero_flag,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_WIDTH-1:0]      op_code,
  output logic [VALUE_WIDTH-1:0]       source1,
  output logic [VALUE_WIDTH-1:0]       source2,
  output logic [VALUE_WIDTH-1:0]       destination,
  output logic [1:0]                   source1_choice,
  output logic [1:0]                   source2_choice,
  output logic [1:0]                   destination_choice,
  output logic                         jmp,
  output logic                         cal,
  output logic                         ret,
  output logic                         push,
  output logic                         pop,
  output logic [PC_WIDTH-1:0]          target_addr,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);
  import decode_opcodes_pkg::*;

  localparam int V      = VALUE_WIDTH;
  localparam int OP_LSB = 3*V + 8;
  localparam int OP_TOP = OP_LSB + OPCODE_WIDTH;
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [OPCODE_WIDTH-1:0] w_op;
  logic [V-1:0]            w_src1;
  logic [V-1:0]            w_src2;
  logic [V-1:0]            w_dst;
  logic [PC_WIDTH-1:0]     w_src1_pc;
  logic [PC_WIDTH-1:0]     w_link;
  logic [PC_WIDTH-1:0]     w_ret_tgt;
  logic                    w_is_jmp;
  logic                    w_is_call;
  logic                    w_is_ret;
  logic                    w_accept;
  logic                    w_unused_rsv;

  logic                    out_valid_q;
  logic [OPCODE_WIDTH-1:0] op_code_q;
  logic [V-1:0]            source1_q;
  logic [V-1:0]            source2_q;
  logic [V-1:0]            destination_q;
  logic [1:0]              src1_ch_q;
  logic [1:0]              src2_ch_q;
  logic [1:0]              dst_ch_q;
  logic                    jmp_q;
  logic                    cal_q;
  logic                    ret_q;
  logic                    push_q;
  logic                    pop_q;
  logic [PC_WIDTH-1:0]     target_q;
  logic                    ras_overflow_q;
  logic                    ras_underflow_q;
  logic [PC_WIDTH-1:0]     ras_q [RAS_DEPTH];
  logic [CNT_W-1:0]        ras_cnt_q;

  assign w_op      = instr[OP_LSB +: OPCODE_WIDTH];
  assign w_src1    = instr[2*V+8 +: V];
  assign w_src2    = instr[V+8 +: V];
  assign w_dst     = instr[8 +: V];
  assign w_src1_pc = w_src1[PC_WIDTH-1:0];
  assign w_link    = pc + PC_WIDTH'(1);
  assign w_ret_tgt = (ras_cnt_q == '0) ? '0 : ras_q[0];

  assign w_unused_rsv = ^instr[7:6];
  generate
    if (INSTRUCTION_WIDTH > OP_TOP) begin : g_spare
      logic w_unused_hi;
      assign w_unused_hi = ^instr[INSTRUCTION_WIDTH-1:OP_TOP];
    end
  endgenerate

  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_comb begin
    w_is_jmp  = 1'b0;
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    case (w_op)
      OPCODE_WIDTH'(OP_JMP):     w_is_jmp  = 1'b1;
      OPCODE_WIDTH'(OP_IF0JUMP): w_is_jmp  = zero_flag;
      OPCODE_WIDTH'(OP_IF1JUMP): w_is_jmp  = ~zero_flag;
      OPCODE_WIDTH'(OP_CALL):    w_is_call = 1'b1;
      OPCODE_WIDTH'(OP_CAL0):    w_is_call = zero_flag;
      OPCODE_WIDTH'(OP_CAL1):    w_is_call = ~zero_flag;
      OPCODE_WIDTH'(OP_RET):     w_is_ret  = 1'b1;
      OPCODE_WIDTH'(OP_RET0):    w_is_ret  = zero_flag;
      OPCODE_WIDTH'(OP_RET1):    w_is_ret  = ~zero_flag;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      op_code_q       <= '0;
      source1_q       <= '0;
      source2_q       <= '0;
      destination_q   <= '0;
      src1_ch_q       <= '0;
      src2_ch_q       <= '0;
      dst_ch_q        <= '0;
      jmp_q           <= 1'b0;
      cal_q           <= 1'b0;
      ret_q           <= 1'b0;
      push_q          <= 1'b0;
      pop_q           <= 1'b0;
      target_q        <= '0;
      ras_overflow_q  <= 1'b0;
      ras_underflow_q <= 1'b0;
      ras_cnt_q       <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (w_accept) begin
      out_valid_q   <= 1'b1;
      op_code_q     <= w_op;
      source1_q     <= w_src1;
      source2_q     <= w_src2;
      destination_q <= w_dst;
      src1_ch_q     <= instr[5:4];
      src2_ch_q     <= instr[3:2];
      dst_ch_q      <= instr[1:0];
      jmp_q         <= w_is_jmp | w_is_call;
      cal_q         <= w_is_call;
      push_q        <= w_is_call;
      ret_q         <= w_is_ret;
      pop_q         <= w_is_ret;
      target_q      <= w_is_ret ? w_ret_tgt : w_src1_pc;
      // Entry 0 is the top; a push into a full stack drops the bottom entry.
      if (w_is_call) begin
        for (int i = RAS_DEPTH-1; i > 0; i--) ras_q[i] <= ras_q[i-1];
        ras_q[0] <= w_link;
        if (ras_cnt_q == CNT_FULL) ras_overflow_q <= 1'b1;
        else                       ras_cnt_q      <= ras_cnt_q + CNT_W'(1);
      end else if (w_is_ret) begin
        if (ras_cnt_q == '0) begin
          ras_underflow_q <= 1'b1;
        end else begin
          for (int i = 0; i < RAS_DEPTH-1; i++) ras_q[i] <= ras_q[i+1];
          ras_q[RAS_DEPTH-1] <= '0;
          ras_cnt_q          <= ras_cnt_q - CNT_W'(1);
        end
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid          = out_valid_q;
  assign op_code            = op_code_q;
  assign source1            = source1_q;
  assign source2            = source2_q;
  assign destination        = destination_q;
  assign source1_choice     = src1_ch_q;
  assign source2_choice     = src2_ch_q;
  assign destination_choice = dst_ch_q;
  assign jmp                = jmp_q;
  assign cal                = cal_q;
  assign ret                = ret_q;
  assign push               = push_q;
  assign pop                = pop_q;
  assign target_addr        = target_q;
  assign ras_overflow       = ras_overflow_q;
  assign ras_underflow      = ras_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Bench for decode_stage: vector table and multi-cycle sequences checked through a scoreboard.
module tb_decode_stage;
  import decode_opcodes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] instr;
  logic [4:0]  pc;
  logic        zero_flag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  op_code;
  logic [7:0]  source1;
  logic [7:0]  source2;
  logic [7:0]  destination;
  logic [1:0]  source1_choice;
  logic [1:0]  source2_choice;
  logic [1:0]  destination_choice;
  logic        jmp;
  logic        cal;
  logic        ret;
  logic        push;
  logic        pop;
  logic [4:0]  target_addr;
  logic        ras_overflow;
  logic        ras_underflow;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instr              (instr),
    .pc                 (pc),
    .zero_flag          (zero_flag),
    .flush              (flush),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .op_code            (op_code),
    .source1            (source1),
    .source2            (source2),
    .destination        (destination),
    .source1_choice     (source1_choice),
    .source2_choice     (source2_choice),
    .destination_choice (destination_choice),
    .jmp                (jmp),
    .cal                (cal),
    .ret                (ret),
    .push               (push),
    .pop                (pop),
    .target_addr        (target_addr),
    .ras_overflow       (ras_overflow),
    .ras_underflow      (ras_underflow)
  );

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] dst;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] cd;
    logic       jmp;
    logic       cal;
    logic       ret;
    logic       push;
    logic       pop;
    logic [4:0] tgt;
  } out_t;

  typedef struct {
    logic [39:0] instr;
    logic [4:0]  pc;
    logic        zero;
    logic        jmp;
    logic [4:0]  tgt;
  } vec_t;

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [39:0] mk(input logic [5:0] op, input logic [7:0] s1,
                                     input logic [7:0] s2, input logic [7:0] dst,
                                     input logic [7:0] ch);
    return {2'b00, op, s1, s2, dst, ch};
  endfunction

  function automatic out_t expect_of(input logic [39:0] ins, input logic j, input logic c,
                                     input logic r, input logic [4:0] t);
    out_t e;
    e.op   = ins[37:32];
    e.s1   = ins[31:24];
    e.s2   = ins[23:16];
    e.dst  = ins[15:8];
    e.c1   = ins[5:4];
    e.c2   = ins[3:2];
    e.cd   = ins[1:0];
    e.jmp  = j;
    e.cal  = c;
    e.push = c;
    e.ret  = r;
    e.pop  = r;
    e.tgt  = t;
    return e;
  endfunction

  function automatic out_t actual();
    out_t a;
    a.op   = op_code;
    a.s1   = source1;
    a.s2   = source2;
    a.dst  = destination;
    a.c1   = source1_choice;
    a.c2   = source2_choice;
    a.cd   = destination_choice;
    a.jmp  = jmp;
    a.cal  = cal;
    a.ret  = ret;
    a.push = push;
    a.pop  = pop;
    a.tgt  = target_addr;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Each transferred output is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    out_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output act=%h exp=none", actual());
      end else begin
        e = sb.pop_front();
        if (actual() !== e) begin
          errors++;
          $display("FAIL out_compare act=%h exp=%h", actual(), e);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] ins, input logic [4:0] p, input logic z, input out_t e);
    int waited = 0;
    in_valid  = 1'b1;
    instr     = ins;
    pc        = p;
    zero_flag = z;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout act=%0d exp=<20", waited);
    end else if (!flush) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [11];
    logic [39:0] ins;
    logic [39:0] x;
    logic [39:0] y;

    tbl[0]  = '{40'h00_0A0B0C15,                        5'd3, 1'b0, 1'b0, 5'h0A};
    tbl[1]  = '{mk(OP_IF0JUMP, 8'h11, 8'h01, 8'h02, 8'h00), 5'd4, 1'b1, 1'b1, 5'h11};
    tbl[2]  = '{mk(OP_IF0JUMP, 8'h11, 8'h01, 8'h02, 8'h00), 5'd5, 1'b0, 1'b0, 5'h11};
    tbl[3]  = '{mk(OP_IF1JUMP, 8'h05, 8'h00, 8'h00, 8'h24), 5'd6, 1'b0, 1'b1, 5'h05};
    tbl[4]  = '{mk(OP_IF1JUMP, 8'h05, 8'h00, 8'h00, 8'h24), 5'd7, 1'b1, 1'b0, 5'h05};
    tbl[5]  = '{mk(OP_JMP,     8'h3F, 8'hAA, 8'h55, 8'h0A), 5'd8, 1'b1, 1'b1, 5'h1F};
    tbl[6]  = '{mk(OP_CAL0,    8'h0C, 8'h00, 8'h00, 8'h00), 5'd9, 1'b0, 1'b0, 5'h0C};
    tbl[7]  = '{mk(OP_CAL1,    8'h0D, 8'h00, 8'h00, 8'h00), 5'd10, 1'b1, 1'b0, 5'h0D};
    tbl[8]  = '{mk(OP_RET0,    8'h0E, 8'h00, 8'h00, 8'h00), 5'd11, 1'b0, 1'b0, 5'h0E};
    tbl[9]  = '{mk(OP_RET1,    8'h0F, 8'h00, 8'h00, 8'h00), 5'd12, 1'b1, 1'b0, 5'h0F};
    tbl[10] = '{mk(6'h3F,      8'hAB, 8'hCD, 8'hEF, 8'hFF), 5'd13, 1'b0, 1'b0, 5'h0B};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    zero_flag = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(actual()), 64'd0);
    chk("reset_flags", 64'({ras_overflow, ras_underflow}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      send(tbl[i].instr, tbl[i].pc, tbl[i].zero,
           expect_of(tbl[i].instr, tbl[i].jmp, 1'b0, 1'b0, tbl[i].tgt));

    ins = mk(OP_CALL, 8'h14, 8'h00, 8'h00, 8'h00);
    send(ins, 5'd7, 1'b0, expect_of(ins, 1'b1, 1'b1, 1'b0, 5'h14));
    ins = mk(OP_RET, 8'h00, 8'h00, 8'h00, 8'h00);
    send(ins, 5'd9, 1'b0, expect_of(ins, 1'b0, 1'b0, 1'b1, 5'h08));

    for (int i = 0; i < 5; i++) begin
      ins = mk(OP_CALL, 8'(16 + i), 8'h00, 8'h00, 8'h00);
      send(ins, 5'(i), 1'b0, expect_of(ins, 1'b1, 1'b1, 1'b0, 5'(16 + i)));
      if (i == 3) chk("overflow_not_yet", 64'(ras_overflow), 64'd0);
    end
    chk("ras_overflow", 64'(ras_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ins = mk(OP_RET, 8'h00, 8'h00, 8'h00, 8'h00);
      send(ins, 5'd20, 1'b0, expect_of(ins, 1'b0, 1'b0, 1'b1, 5'(5 - i)));
    end
    chk("underflow_not_yet", 64'(ras_underflow), 64'd0);
    ins = mk(OP_RET, 8'h00, 8'h00, 8'h00, 8'h00);
    send(ins, 5'd21, 1'b0, expect_of(ins, 1'b0, 1'b0, 1'b1, 5'h00));
    chk("ras_underflow", 64'(ras_underflow), 64'd1);

    idle(2);
    out_ready = 1'b0;
    x = mk(6'h01, 8'h21, 8'h22, 8'h23, 8'h06);
    send(x, 5'd1, 1'b0, expect_of(x, 1'b0, 1'b0, 1'b0, 5'h01));
    y = mk(6'h02, 8'h31, 8'h32, 8'h33, 8'h09);
    in_valid  = 1'b1;
    instr     = y;
    pc        = 5'd2;
    zero_flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'(actual()), 64'(expect_of(x, 1'b0, 1'b0, 1'b0, 5'h01)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(y, 5'd2, 1'b0, expect_of(y, 1'b0, 1'b0, 1'b0, 5'h11));
    idle(2);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    ins = mk(OP_CALL, 8'h02, 8'h00, 8'h00, 8'h00);
    send(ins, 5'h0A, 1'b0, expect_of(ins, 1'b1, 1'b1, 1'b0, 5'h02));
    idle(2);
    flush = 1'b1;
    ins = mk(OP_CALL, 8'h03, 8'h00, 8'h00, 8'h00);
    send(ins, 5'h1B, 1'b0, expect_of(ins, 1'b1, 1'b1, 1'b0, 5'h03));
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    ins = mk(OP_RET, 8'h00, 8'h00, 8'h00, 8'h00);
    send(ins, 5'd3, 1'b0, expect_of(ins, 1'b0, 1'b0, 1'b1, 5'h0B));
    idle(2);
    chk("flush_drained", 64'(sb.size()), 64'd0);

    ins = mk(OP_JMP, 8'h07, 8'h00, 8'h00, 8'h3F);
    send(ins, 5'd4, 1'b1, expect_of(ins, 1'b1, 1'b0, 1'b0, 5'h07));
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    chk("pre_reset_flags", 64'({ras_overflow, ras_underflow}), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", 64'(actual()), 64'd0);
    chk("midreset_flags", 64'({ras_overflow, ras_underflow}), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
